srcnn_mul_rr_arbiter: RTL and testbench
=======================================

SRCNN_MUL_RR_ARBITER -- requirements
Module: srcnn_mul_rr_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters sharing one multiplier.
REQ-002 Parameter A_W, default 7, unsigned operand A width.
REQ-003 Parameter B_W, default 8, unsigned operand B width.
REQ-004 Parameter P_W, default 13, result width; must satisfy P_W <= A_W+B_W.
REQ-005 Parameter ID_W, default 2, requester-index width; must satisfy 2^ID_W >= NREQ.
REQ-006 ap_clk  in  1  the single clock; all state changes on its rising edge.
REQ-007 ap_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 req_valid  in  NREQ  bit i = requester i presents an operand pair.
REQ-009 req_ready  out  NREQ  bit i = requester i's operands are consumed this cycle.
REQ-010 req_a  in  NREQ*A_W  slice i = operand A of requester i (unsigned).
REQ-011 req_b  in  NREQ*B_W  slice i = operand B of requester i (unsigned).
REQ-012 res_valid  out  1  result register holds a valid product.
REQ-013 res_ready  in  1  downstream accepts the result this cycle.
REQ-014 res_data  out  P_W  product, low P_W bits.
REQ-015 res_id  out  ID_W  index of the requester that owns res_data.
REQ-016 op_cnt  out  16  count of completed result transfers.

Function
REQ-017 Transfer rule, both sides: a transfer occurs when valid and ready are both high at a rising edge; a requester holds valid and operands stable until its ready.
REQ-018 can_accept = !res_valid || res_ready (slot empty, or being drained in the same cycle).
REQ-019 At most one req_ready bit is high per cycle: the winner, and only when can_accept=1; all bits are 0 when can_accept=0 or no req_valid is high.
REQ-020 req_ready is combinational from req_valid, the priority pointer, res_valid and res_ready; it does not depend on req_a or req_b.
REQ-021 Round-robin winner: first i with req_valid[i]=1, searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
REQ-022 On a transfer from requester i, ptr becomes (i+1) mod NREQ; otherwise ptr holds.
REQ-023 On a transfer from requester i, the next edge sets res_valid=1, res_id=i and res_data=(zero-extended a_i * zero-extended b_i) mod 2^P_W.
REQ-024 Latency from request transfer to res_valid is one cycle.
REQ-025 Throughput is one product per cycle while res_ready=1.
REQ-026 Result-register states: EMPTY, FULL.
- EMPTY -> FULL on a request transfer.
- FULL -> FULL on a result transfer with a simultaneous request transfer; register reloads with no bubble.
- FULL -> EMPTY on a result transfer with no request transfer.
- FULL holds with res_valid=1 and res_data/res_id stable while res_ready=0.
REQ-027 op_cnt increments by 1 on each result transfer and wraps from 65535 to 0.
REQ-028 Multiplication is a single combinational unsigned multiply feeding the result register; there is exactly one multiplier instance regardless of NREQ.
REQ-029 Operands of non-granted requesters never affect res_data.

Reset
REQ-030 While ap_rst_n=0: res_valid=0, res_data=0, res_id=0, op_cnt=0, ptr=0, req_ready=0 (asynchronous; no clock needed).
REQ-031 Reset asserted mid-operation discards any held result; no result transfer is reported for it.
REQ-032 After deassertion, the first edge may accept a request, with requester 0 at highest priority.

Verification
REQ-033 Single request, ptr=0, res_ready=1: req_valid=001, a0=127, b0=255 -> req_ready=001 that cycle; next cycle res_valid=1, res_data=7809, res_id=0, op_cnt=1.
REQ-034 Fairness: req_valid=111 held, res_ready=1, incrementing operands -> res_id sequence 0,1,2,0,1,2, one result per cycle, no bubbles.
REQ-035 Pointer: grant to 2, then req_valid=011 -> 0 granted; after grant to 0, req_valid=101 -> 2 granted before 0.
REQ-036 Backpressure: res_valid=1, res_ready=0 for 5 cycles with req_valid=111 -> req_ready=000, res_data and res_id unchanged, op_cnt unchanged; on res_ready=1, drain and accept occur in the same cycle.
REQ-037 Reset mid-operation: ap_rst_n low between clock edges while FULL -> outputs are 0 immediately; after release, req_valid=110 -> requester 1 granted first.
REQ-038 Wrap: 65536 result transfers -> op_cnt returns to 0; a=127, b=255 with P_W=13 -> 7809, confirming truncation.

Source files
------------

// File: rtl/srcnn_mul_rr_arbiter.sv
// Round-robin arbiter sharing one unsigned multiplier among NREQ requesters,
// with a single-entry result register (EMPTY/FULL) and a transfer counter.
module srcnn_mul_rr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned A_W  = 7,
  parameter int unsigned B_W  = 8,
  parameter int unsigned P_W  = 13,
  parameter int unsigned ID_W = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*A_W-1:0]   req_a,
  input  logic [NREQ*B_W-1:0]   req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [P_W-1:0]        res_data,
  output logic [ID_W-1:0]       res_id,
  output logic [15:0]           op_cnt
);

  localparam int unsigned PF_W = A_W + B_W;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   ptr_next;
  logic [ID_W-1:0]   grant_id;
  logic              grant_found;
  logic              can_accept;
  logic              req_xfer;
  logic              res_xfer;
  int unsigned       idx;
  logic [NREQ-1:0]   vshift;
  logic [A_W-1:0]    a_sel;
  logic [B_W-1:0]    b_sel;
  logic [P_W-1:0]    prod;

  // Round-robin search starting at ptr_q, wrapping through NREQ-1 back to 0.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    vshift      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      vshift = req_valid >> idx;
      if (!grant_found && vshift[0]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Handshake decode; ready is forced low while reset is held.
  always_comb begin
    can_accept = !res_valid || res_ready;
    req_ready  = '0;
    if (ap_rst_n && can_accept && grant_found) req_ready = NREQ'(1) << grant_id;
    req_xfer   = |req_ready;
    res_xfer   = res_valid && res_ready;
  end

  // Operand mux driven only by the winner, feeding the single multiplier.
  always_comb begin
    a_sel    = A_W'(req_a >> (32'(grant_id) * A_W));
    b_sel    = B_W'(req_b >> (32'(grant_id) * B_W));
    prod     = P_W'(PF_W'(a_sel) * PF_W'(b_sel));
    ptr_next = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
  end

  // Result-register state.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= S_EMPTY;
    else           state_q <= state_d;
  end

  // Next state: a request transfer always fills; a drain without refill empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (req_xfer) state_d = S_FULL;
      S_FULL:  if (!req_xfer && res_ready) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // State-decoded output.
  always_comb begin
    res_valid = (state_q == S_FULL);
  end

  // Result payload, round-robin pointer and transfer counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      res_data <= '0;
      res_id   <= '0;
      ptr_q    <= '0;
      op_cnt   <= '0;
    end else begin
      if (req_xfer) begin
        res_data <= prod;
        res_id   <= grant_id;
        ptr_q    <= ptr_next;
      end
      if (res_xfer) op_cnt <= op_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_srcnn_mul_rr_arbiter.sv
// Scoreboard bench: a predictor models arbitration and pushes expected
// results; a monitor pops and compares whenever a result is presented.
module tb_srcnn_mul_rr_arbiter;

  localparam int NREQ = 3;
  localparam int A_W  = 7;
  localparam int B_W  = 8;
  localparam int P_W  = 13;
  localparam int ID_W = 2;

  logic                ap_clk = 1'b0;
  logic                ap_rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic                res_valid;
  logic                res_ready;
  logic [P_W-1:0]      res_data;
  logic [ID_W-1:0]     res_id;
  logic [15:0]         op_cnt;

  srcnn_mul_rr_arbiter #(
    .NREQ(NREQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .ID_W(ID_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .op_cnt(op_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int id;
    int data;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          in_reset = 1'b1;
  int          m_ptr = 0;
  bit          m_full = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [NREQ-1:0] last_ready = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Predictor: expected grant from the round-robin rule, pushes products.
  always @(negedge ap_clk) begin
    if (!in_reset && ap_rst_n) begin
      int w;
      logic [NREQ-1:0] exp_ready;
      w = -1;
      exp_ready = '0;
      check("res_valid_state", 32'(res_valid), 32'(m_full));
      if (!m_full || res_ready) begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_ptr + k) % NREQ;
          if (w < 0 && req_valid[i]) w = i;
        end
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      if (w >= 0) begin
        exp_t e;
        int av, bv;
        av = int'(req_a[w*A_W +: A_W]);
        bv = int'(req_b[w*B_W +: B_W]);
        e.id = w;
        e.data = (av * bv) % (1 << P_W);
        sb_q.push_back(e);
        m_ptr = (w + 1) % NREQ;
        m_full = 1'b1;
      end else if (res_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: compares presented results against the scoreboard head.
  always @(negedge ap_clk) begin
    if (!in_reset && ap_rst_n) begin
      check("op_cnt", 32'(op_cnt), 32'(m_cnt));
      if (res_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_unexpected actual=id%0d/%0d expected=none @%0t", res_id, res_data, $time);
        end else begin
          check("res_id", 32'(res_id), 32'(sb_q[0].id));
          check("res_data", 32'(res_data), 32'(sb_q[0].data));
          if (res_ready) begin
            void'(sb_q.pop_front());
            m_cnt = m_cnt + 16'd1;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(negedge ap_clk);
    last_ready = req_ready;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_ptr = 0;
    m_full = 1'b0;
    m_cnt = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [P_W-1:0]  hold_data;
    logic [ID_W-1:0] hold_id;
    logic [15:0]     hold_cnt;
    logic [15:0]     base_cnt;
    int              fair_ids[6];
    fair_ids = '{0, 1, 2, 0, 1, 2};

    ap_rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_op_cnt", 32'(op_cnt), 0);
    model_reset();
    ap_rst_n = 1'b1;
    in_reset = 1'b0;

    // Single request, ptr=0: 127*255 truncated to 13 bits.
    req_valid = 3'b001;
    req_a[0 +: A_W] = 7'd127;
    req_b[0 +: B_W] = 8'd255;
    res_ready = 1'b1;
    cyc();
    check("single_ready", 32'(last_ready), 32'b001);
    check("single_data", 32'(res_data), 7809);
    check("single_id", 32'(res_id), 0);
    req_valid = 3'b100;
    cyc();
    check("grant2_id", 32'(res_id), 2);

    // Fairness: all valid, one result per cycle in 0,1,2 order.
    req_valid = 3'b111;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (n == 0 || last_ready[i]) begin
          req_a[i*A_W +: A_W] = A_W'(10 + n + i);
          req_b[i*B_W +: B_W] = B_W'(20 + n * 3 + i);
        end
      end
      cyc();
      check("fair_valid", 32'(res_valid), 1);
      check("fair_id", 32'(res_id), 32'(fair_ids[n]));
    end

    // Pointer: grant 2, then 011 -> 0, then 101 -> 2.
    req_valid = 3'b100;
    cyc();
    check("ptr_a", 32'(res_id), 2);
    req_valid = 3'b011;
    cyc();
    check("ptr_b", 32'(res_id), 0);
    req_valid = 3'b101;
    cyc();
    check("ptr_c", 32'(res_id), 2);

    // Backpressure with everyone requesting.
    req_valid = 3'b111;
    res_ready = 1'b0;
    hold_data = res_data;
    hold_id = res_id;
    hold_cnt = op_cnt;
    repeat (5) begin
      cyc();
      check("bp_ready", 32'(last_ready), 0);
      check("bp_data", 32'(res_data), 32'(hold_data));
      check("bp_id", 32'(res_id), 32'(hold_id));
      check("bp_cnt", 32'(op_cnt), 32'(hold_cnt));
    end
    res_ready = 1'b1;
    cyc();
    check("bp_release_accept", 32'(last_ready != 0), 1);
    check("bp_release_cnt", 32'(op_cnt), 32'(hold_cnt + 16'd1));

    // Random traffic with protocol-respecting requesters.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_ready[i] || !req_valid[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_a[i*A_W +: A_W] = A_W'($urandom);
          req_b[i*B_W +: B_W] = B_W'($urandom);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // Reset mid-operation while FULL.
    req_valid = 3'b001;
    req_a[0 +: A_W] = 7'd99;
    res_ready = 1'b1;
    cyc();
    check("pre_rst_full", 32'(res_valid), 1);
    req_valid = 3'b111;
    res_ready = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(res_valid), 0);
    check("mid_rst_data", 32'(res_data), 0);
    check("mid_rst_id", 32'(res_id), 0);
    check("mid_rst_cnt", 32'(op_cnt), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    @(posedge ap_clk);
    #1;
    model_reset();
    req_valid = 3'b110;
    res_ready = 1'b1;
    ap_rst_n = 1'b1;
    in_reset = 1'b0;
    cyc();
    check("post_rst_ready", 32'(last_ready), 32'b010);
    check("post_rst_id", 32'(res_id), 1);
    req_valid = 3'b000;
    cyc();

    // Counter wrap: exactly 65536 result transfers return op_cnt to its start.
    base_cnt = op_cnt;
    req_valid = 3'b001;
    req_a[0 +: A_W] = 7'd127;
    req_b[0 +: B_W] = 8'd255;
    repeat (65536) cyc();
    check("wrap_data", 32'(res_data), 7809);
    req_valid = 3'b000;
    cyc();
    check("wrap_cnt", 32'(op_cnt), 32'(base_cnt));
    check("wrap_empty", 32'(res_valid), 0);
    check("sb_drained", 32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
